// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: default widths,
// condition-code bit positions and the control bundle carried to MEM.
package ex_mem_pkg;

    localparam int DATA_W_DEFAULT  = 16;
    localparam int RADDR_W_DEFAULT = 3;
    localparam int FLAG_W_DEFAULT  = 3;

    // Condition-code bit positions inside the CCR
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    // Memory/writeback control bits that travel with the instruction
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_pipe_reg_ccr_reg.sv
// Architectural condition-code register with a one-deep shadow copy used
// across interrupt entry (save) and return-from-interrupt (restore).
module ccr_reg
    import ex_mem_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic [FLAG_W-1:0] mask,
    input  logic [FLAG_W-1:0] flags,
    input  logic              save,
    input  logic              restore,
    output logic [FLAG_W-1:0] ccr_q,
    output logic [FLAG_W-1:0] ccr_shadow_q
);

    logic [FLAG_W-1:0] ccr_merged;

    // Per-flag merge: enabled flags come from the ALU, the rest keep their value
    always_comb begin
        ccr_merged = (ccr_q & ~mask) | (flags & mask);
    end

    // Commit the CCR; restore beats both the mask and a simultaneous save,
    // and the shadow captures the post-commit value on interrupt entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_q        <= '0;
            ccr_shadow_q <= '0;
        end else if (commit) begin
            if (restore) begin
                ccr_q <= ccr_shadow_q;
            end else begin
                ccr_q <= ccr_merged;
                if (save) begin
                    ccr_shadow_q <= ccr_merged;
                end
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline boundary: registers the execute-stage result, store data,
// destination and control bits, and owns the architectural CCR (via ccr_reg).
// Flush inserts a bubble, stall freezes everything, otherwise EX is captured.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int RADDR_W = RADDR_W_DEFAULT,
    parameter int FLAG_W  = FLAG_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic [FLAG_W-1:0]  ex_ccr,
    input  logic [FLAG_W-1:0]  ex_flag_en,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic               ex_int_save,
    input  logic               ex_rti_restore,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               mem_reg_write,
    output logic [FLAG_W-1:0]  ccr_q,
    output logic [FLAG_W-1:0]  ccr_shadow_q
);

    ex_mem_ctrl_t ex_ctrl;
    ex_mem_ctrl_t mem_ctrl;
    logic         capture;
    logic         commit;

    // Bundle the EX control bits, qualified so a bubble can never carry a side effect
    always_comb begin
        ex_ctrl.mem_read  = ex_mem_read  & ex_valid;
        ex_ctrl.mem_write = ex_mem_write & ex_valid;
        ex_ctrl.reg_write = ex_reg_write & ex_valid;
    end

    // Capture happens only when neither flush nor stall is active; the CCR
    // additionally requires a real instruction
    always_comb begin
        capture = ~flush & ~stall;
        commit  = capture & ex_valid;
    end

    // Pipeline register: flush clears, stall holds, otherwise load from EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_ctrl       <= '0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_ctrl       <= '0;
        end else if (capture) begin
            mem_valid      <= ex_valid;
            mem_alu_result <= ex_alu_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_ctrl       <= ex_ctrl;
        end
    end

    assign mem_mem_read  = mem_ctrl.mem_read;
    assign mem_mem_write = mem_ctrl.mem_write;
    assign mem_reg_write = mem_ctrl.reg_write;

    ccr_reg #(
        .FLAG_W (FLAG_W)
    ) u_ccr_reg (
        .clk          (clk),
        .rst          (rst),
        .commit       (commit),
        .mask         (ex_flag_en),
        .flags        (ex_ccr),
        .save         (ex_int_save),
        .restore      (ex_rti_restore),
        .ccr_q        (ccr_q),
        .ccr_shadow_q (ccr_shadow_q)
    );

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_ex_mem_pipe_reg;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, ex_valid;
    logic [DW-1:0] ex_alu_result, ex_store_data;
    logic [FW-1:0] ex_ccr, ex_flag_en;
    logic [AW-1:0] ex_rd;
    logic          ex_mem_read, ex_mem_write, ex_reg_write;
    logic          ex_int_save, ex_rti_restore;
    logic          mem_valid;
    logic [DW-1:0] mem_alu_result, mem_store_data;
    logic [AW-1:0] mem_rd;
    logic          mem_mem_read, mem_mem_write, mem_reg_write;
    logic [FW-1:0] ccr_q, ccr_shadow_q;

    int checks = 0;
    int errors = 0;

    // Reference state of the stage
    logic          m_valid;
    logic [DW-1:0] m_alu, m_sd;
    logic [AW-1:0] m_rd;
    logic          m_rd_en, m_wr_en, m_wb_en;
    logic [FW-1:0] m_ccr, m_shadow;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_ccr         (ex_ccr),
        .ex_flag_en     (ex_flag_en),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_int_save    (ex_int_save),
        .ex_rti_restore (ex_rti_restore),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .ccr_q          (ccr_q),
        .ccr_shadow_q   (ccr_shadow_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_alu = '0; m_sd = '0; m_rd = '0;
        m_rd_en = 0; m_wr_en = 0; m_wb_en = 0;
        m_ccr = '0; m_shadow = '0;
    endtask

    // Apply the stage rules for one rising edge to the model
    task automatic model_edge();
        logic [FW-1:0] nxt;
        if (flush) begin
            m_valid = 0; m_alu = '0; m_sd = '0; m_rd = '0;
            m_rd_en = 0; m_wr_en = 0; m_wb_en = 0;
        end else if (!stall) begin
            m_valid = ex_valid; m_alu = ex_alu_result; m_sd = ex_store_data; m_rd = ex_rd;
            m_rd_en = ex_valid && ex_mem_read;
            m_wr_en = ex_valid && ex_mem_write;
            m_wb_en = ex_valid && ex_reg_write;
            if (ex_valid) begin
                if (ex_rti_restore) begin
                    m_ccr = m_shadow;
                end else begin
                    for (int b = 0; b < FW; b++)
                        nxt[b] = ex_flag_en[b] ? ex_ccr[b] : m_ccr[b];
                    m_ccr = nxt;
                    if (ex_int_save) m_shadow = nxt;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, mem_valid, m_valid);
        chk({tag, ".alu"}, mem_alu_result, m_alu);
        chk({tag, ".sd"}, mem_store_data, m_sd);
        chk({tag, ".rd"}, mem_rd, m_rd);
        chk({tag, ".mrd"}, mem_mem_read, m_rd_en);
        chk({tag, ".mwr"}, mem_mem_write, m_wr_en);
        chk({tag, ".wb"}, mem_reg_write, m_wb_en);
        chk({tag, ".ccr"}, ccr_q, m_ccr);
        chk({tag, ".shadow"}, ccr_shadow_q, m_shadow);
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("step %-10s st=%0b fl=%0b v=%0b alu=%h rd=%0d ccr=%b sh=%b",
                 tag, stall, flush, ex_valid, mem_alu_result, mem_rd, ccr_q, ccr_shadow_q);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; ex_valid = 0;
        ex_alu_result = '0; ex_store_data = '0; ex_ccr = '0; ex_flag_en = '0; ex_rd = '0;
        ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
        ex_int_save = 0; ex_rti_restore = 0;
    endtask

    // Valid instruction that only changes the CCR
    task automatic flag_op(input logic [FW-1:0] f, input logic [FW-1:0] m,
                           input logic sv, input logic rs, input string tag);
        idle_inputs();
        ex_valid = 1; ex_ccr = f; ex_flag_en = m; ex_int_save = sv; ex_rti_restore = rs;
        step(tag);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        #1;
        check_all("reset0");
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Capture of a writeback instruction
        ex_valid = 1; ex_alu_result = 16'h1234; ex_rd = 3'd5; ex_reg_write = 1;
        ex_store_data = 16'hBEEF;
        step("capture");
        chk("cap.alu_const", mem_alu_result, 16'h1234);
        chk("cap.rd_const", mem_rd, 3'd5);
        chk("cap.wb_const", mem_reg_write, 1'b1);

        // Masked flag commit
        flag_op(3'b001, 3'b111, 0, 0, "setccr");
        flag_op(3'b110, 3'b010, 0, 0, "mask");
        chk("mask.ccr_const", ccr_q, 3'b011);

        // Stall twice with fresh inputs, then flush while still stalled
        idle_inputs();
        ex_valid = 1; ex_alu_result = 16'hA5A5; ex_rd = 3'd2; ex_mem_write = 1;
        step("load");
        ex_alu_result = 16'h0F0F; ex_rd = 3'd7; ex_ccr = 3'b111; ex_flag_en = 3'b111;
        ex_mem_read = 1; stall = 1;
        step("stall1");
        step("stall2");
        chk("stall.alu_const", mem_alu_result, 16'hA5A5);
        flush = 1;
        step("flushst");
        chk("flush.valid_const", mem_valid, 1'b0);
        chk("flush.ccr_const", ccr_q, 3'b011);

        // Interrupt save with empty mask, then restore after the ALU changes flags
        flag_op(3'b101, 3'b111, 0, 0, "ccr101");
        flag_op(3'b010, 3'b000, 1, 0, "save");
        chk("save.shadow_const", ccr_shadow_q, 3'b101);
        flag_op(3'b010, 3'b111, 0, 0, "ccr010");
        flag_op(3'b000, 3'b111, 0, 1, "restore");
        chk("restore.ccr_const", ccr_q, 3'b101);

        // Save and restore together: restore wins, shadow unchanged
        flag_op(3'b011, 3'b111, 1, 0, "sh011");
        flag_op(3'b100, 3'b111, 0, 0, "ccr100");
        flag_op(3'b111, 3'b111, 1, 1, "savrst");
        chk("both.ccr_const", ccr_q, 3'b011);
        chk("both.shadow_const", ccr_shadow_q, 3'b011);

        // Bubble with mask/save/restore asserted must not touch the CCR
        flag_op(3'b111, 3'b111, 1, 1, "prebub");
        ex_valid = 0;
        step("bubble");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            stall          = ($urandom_range(0, 4) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_alu_result  = DW'($urandom);
            ex_store_data  = DW'($urandom);
            ex_ccr         = FW'($urandom);
            ex_flag_en     = FW'($urandom);
            ex_rd          = AW'($urandom);
            ex_mem_read    = 1'($urandom);
            ex_mem_write   = 1'($urandom);
            ex_reg_write   = 1'($urandom);
            ex_int_save    = ($urandom_range(0, 5) == 0);
            ex_rti_restore = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        // Asynchronous reset mid-run from a nonzero state
        idle_inputs();
        ex_valid = 1; ex_alu_result = 16'hFFFF; ex_store_data = 16'h5555; ex_rd = 3'd6;
        ex_reg_write = 1; ex_mem_read = 1; ex_ccr = 3'b111; ex_flag_en = 3'b111;
        ex_int_save = 1;
        step("prerst");
        #3;
        rst = 1;
        model_reset();
        #1;
        check_all("asyncrst");
        #1;
        rst = 0;
        idle_inputs();
        step("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
